load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 63 ++++++
 rtl/load_extend.sv | 28 ++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, the Funct3 size encodings and the captured-operation struct.
// Also holds the pure helpers for fault, byte-enable and store-lane computation.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Operation as captured at accept time; only the low address bits are
    // needed after the request has been issued.
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] lane;
    } control_operation;

    // Misaligned halves/words, undefined encodings, and unsigned stores.
    function automatic logic op_fault(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] lane);
        logic f;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = lane[0];
            F3_W:    f = |lane;
            F3_BU:   f = is_store;
            F3_HU:   f = is_store | lane[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    // funct3[1:0] is the size field; BU/HU share enables with B/H.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] lane);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the byte/half across all lanes so the enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wd);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the addressed byte/half from a read word and extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: funct3/lane select the access, rdata is the raw word, data is the extended result.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, issues one word-aligned memory request.
// Latency: accept N, MemReq N+1, Done one cycle after MemAck; faults complete at N+1 without MemReq.
// Backpressure: Ready only in IDLE; memory side holds MemReq and all request fields until MemAck.
// Ports: execute side Valid/Ready/MemRead/MemWrite/Funct3/ALUResult/WriteData,
//        response Done/ReadData/Fault, memory side MemReq/MemWe/MemAddr/MemBe/MemWdata/MemAck/MemRdata.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Valid,
    output logic                  Ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Fault,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [3:0]            MemBe,
    output logic [DATA_WIDTH-1:0] MemWdata,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRdata
);

    state_t           state_q, state_d;
    control_operation op_q;
    logic             fault_q;
    logic             we_q;
    logic [31:0]      addr_q, wdata_q, rdata_q, ext_data;
    logic [3:0]       be_q;

    logic accept, in_store, in_fault;

    // A simultaneous read+write is a load.
    assign in_store = MemWrite & ~MemRead;
    assign in_fault = op_fault(in_store, Funct3, ALUResult[1:0]);
    assign accept   = (state_q == IDLE) & Valid & (MemRead | MemWrite);

    load_extend u_load_extend (
        .funct3 (op_q.funct3),
        .lane   (op_q.lane),
        .rdata  (MemRdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= '{is_store: in_store, funct3: Funct3, lane: ALUResult[1:0]};
                fault_q <= in_fault;
                rdata_q <= '0;
                // Faulting ops never reach memory, so leave the request fields alone.
                if (!in_fault) begin
                    we_q    <= in_store;
                    addr_q  <= {ALUResult[31:2], 2'b00};
                    be_q    <= byte_enables(Funct3, ALUResult[1:0]);
                    wdata_q <= store_lanes(Funct3, WriteData);
                end
            end
            if ((state_q == ACCESS) && MemAck && !op_q.is_store) begin
                rdata_q <= ext_data;
            end
        end
    end

    // Outputs decode from registered state only, so MemAck never reaches Ready/Done combinationally.
    always_comb begin
        state_d = state_q;
        Ready   = 1'b0;
        Done    = 1'b0;
        Fault   = 1'b0;
        MemReq  = 1'b0;
        case (state_q)
            IDLE: begin
                Ready = 1'b1;
                if (accept) state_d = in_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                MemReq = 1'b1;
                if (MemAck) state_d = RESP;
            end
            RESP: begin
                Done    = 1'b1;
                Fault   = fault_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemBe    = be_q;
    assign MemWdata = wdata_q;
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid, Ready, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic        Done, Fault;
    logic [31:0] ReadData;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWdata;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Valid     (Valid),
        .Ready     (Ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Done      (Done),
        .ReadData  (ReadData),
        .Fault     (Fault),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemBe     (MemBe),
        .MemWdata  (MemWdata),
        .MemAck    (MemAck),
        .MemRdata  (MemRdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one op starting at a negedge in IDLE; all checks are cycle-exact so
    // the latency is verified by where each check lands.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits, input logic flt,
                          input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewe,
                          input logic [31:0] ewdata, input logic [31:0] eres);
        check({tag, ".ready"}, {31'h0, Ready}, 32'h1);
        Valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; WriteData = wd;
        @(negedge clk);
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        if (flt) begin
            check({tag, ".req"},   {31'h0, MemReq}, 32'h0);
            check({tag, ".done"},  {31'h0, Done},   32'h1);
            check({tag, ".fault"}, {31'h0, Fault},  32'h1);
            check({tag, ".rdata"}, ReadData,        32'h0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                check({tag, ".req"},   {31'h0, MemReq}, 32'h1);
                check({tag, ".addr"},  MemAddr,         eaddr);
                check({tag, ".be"},    {28'h0, MemBe},  {28'h0, ebe});
                check({tag, ".we"},    {31'h0, MemWe},  {31'h0, ewe});
                check({tag, ".wdata"}, MemWdata,        ewdata);
                check({tag, ".done0"}, {31'h0, Done},   32'h0);
                if (i == waits) begin
                    MemAck = 1'b1; MemRdata = rdat;
                end else begin
                    MemRdata = 32'h5A5A5A5A;
                end
                @(negedge clk);
            end
            MemAck = 1'b0;
            check({tag, ".done"},  {31'h0, Done},   32'h1);
            check({tag, ".fault"}, {31'h0, Fault},  32'h0);
            check({tag, ".rdata"}, ReadData,        eres);
            check({tag, ".req1"},  {31'h0, MemReq}, 32'h0);
        end
        @(negedge clk);
        check({tag, ".idle_done"},  {31'h0, Done},  32'h0);
        check({tag, ".idle_fault"}, {31'h0, Fault}, 32'h0);
        check({tag, ".idle_ready"}, {31'h0, Ready}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0; MemAck = 1'b0; MemRdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.ready", {31'h0, Ready}, 32'h1);
        check("rst.done",  {31'h0, Done},  32'h0);
        check("rst.fault", {31'h0, Fault}, 32'h0);
        check("rst.req",   {31'h0, MemReq}, 32'h0);
        check("rst.we",    {31'h0, MemWe}, 32'h0);
        check("rst.be",    {28'h0, MemBe}, 32'h0);
        check("rst.addr",  MemAddr,  32'h0);
        check("rst.wdata", MemWdata, 32'h0);
        check("rst.rdata", ReadData, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        //      tag    rd    wr    f3      addr          wd            rdat          wt flt eaddr         be       we    ewdata        eres
        run_op("sw",   1'b0, 1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h00000100, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0);
        run_op("lb",   1'b1, 1'b0, 3'b000, 32'h00000203, 32'h0,        32'h80FF7F01, 0, 0, 32'h00000200, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80);
        run_op("lbu",  1'b1, 1'b0, 3'b100, 32'h00000203, 32'h0,        32'h80FF7F01, 0, 0, 32'h00000200, 4'b1000, 1'b0, 32'h0,        32'h00000080);
        run_op("lh_w", 1'b1, 1'b0, 3'b001, 32'h00000002, 32'h0,        32'h8001ABCD, 3, 0, 32'h00000000, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001);
        run_op("lhu",  1'b1, 1'b0, 3'b101, 32'h00000000, 32'h0,        32'h8001ABCD, 1, 0, 32'h00000000, 4'b0011, 1'b0, 32'h0,        32'h0000ABCD);
        run_op("lb1",  1'b1, 1'b0, 3'b000, 32'h00000301, 32'h0,        32'h80FF7F01, 0, 0, 32'h00000300, 4'b0010, 1'b0, 32'h0,        32'h0000007F);
        run_op("sb",   1'b0, 1'b1, 3'b000, 32'h00000101, 32'h000000AB, 32'h0,        0, 0, 32'h00000100, 4'b0010, 1'b1, 32'hABABABAB, 32'h0);
        run_op("sh",   1'b0, 1'b1, 3'b001, 32'h00000006, 32'h00001234, 32'h0,        2, 0, 32'h00000004, 4'b1100, 1'b1, 32'h12341234, 32'h0);
        run_op("rdwr", 1'b1, 1'b1, 3'b010, 32'h00000010, 32'h99999999, 32'h11223344, 0, 0, 32'h00000010, 4'b1111, 1'b0, 32'h99999999, 32'h11223344);
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h00000006, 32'h0,      32'h0,        0, 1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0);
        run_op("sbu",  1'b0, 1'b1, 3'b100, 32'h00000000, 32'h0,        32'h0,        0, 1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0);
        run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h00000001, 32'h0,      32'h0,        0, 1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0);
        run_op("f3_011", 1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,      32'h0,        0, 1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0);

        // Valid without read or write is ignored.
        Valid = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0;
        @(negedge clk);
        Valid = 1'b0;
        check("nop.ready", {31'h0, Ready},  32'h1);
        check("nop.req",   {31'h0, MemReq}, 32'h0);
        check("nop.done",  {31'h0, Done},   32'h0);

        // Reset in the second ACCESS cycle abandons the op.
        Valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h00000020;
        @(negedge clk);
        Valid = 1'b0; MemRead = 1'b0;
        check("rsta.req1", {31'h0, MemReq}, 32'h1);
        @(negedge clk);
        check("rsta.req2", {31'h0, MemReq}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rsta.req",   {31'h0, MemReq}, 32'h0);
        check("rsta.ready", {31'h0, Ready},  32'h1);
        check("rsta.done",  {31'h0, Done},   32'h0);
        check("rsta.addr",  MemAddr,         32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rsta.done2", {31'h0, Done},  32'h0);
        check("rsta.ready2", {31'h0, Ready}, 32'h1);

        // Valid held across an op: second op enters only after RESP.
        Valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h00000040;
        @(negedge clk);
        check("b2b.req1", {31'h0, MemReq}, 32'h1);
        check("b2b.addr1", MemAddr, 32'h00000040);
        MemAck = 1'b1; MemRdata = 32'hCAFEF00D;
        @(negedge clk);
        MemAck = 1'b0;
        check("b2b.done1",  {31'h0, Done},  32'h1);
        check("b2b.rdata1", ReadData,       32'hCAFEF00D);
        check("b2b.ready_resp", {31'h0, Ready}, 32'h0);
        ALUResult = 32'h00000044;
        @(negedge clk);
        check("b2b.idle_ready", {31'h0, Ready},  32'h1);
        check("b2b.idle_req",   {31'h0, MemReq}, 32'h0);
        check("b2b.idle_done",  {31'h0, Done},   32'h0);
        @(negedge clk);
        Valid = 1'b0; MemRead = 1'b0;
        check("b2b.req2",  {31'h0, MemReq}, 32'h1);
        check("b2b.addr2", MemAddr,         32'h00000044);
        MemAck = 1'b1; MemRdata = 32'h12345678;
        @(negedge clk);
        MemAck = 1'b0;
        check("b2b.done2",  {31'h0, Done}, 32'h1);
        check("b2b.rdata2", ReadData,      32'h12345678);
        @(negedge clk);
        // Stray MemAck while idle.
        MemAck = 1'b1;
        @(negedge clk);
        MemAck = 1'b0;
        check("stray.done",  {31'h0, Done},   32'h0);
        check("stray.ready", {31'h0, Ready},  32'h1);
        check("stray.req",   {31'h0, MemReq}, 32'h0);
        @(negedge clk);
        check("stray.done2", {31'h0, Done},   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
